// File: rtl/comida_pkg.sv
// Shared definitions for the food-level controller: FSM state codes and level limits.
package comida_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FEEDING = 2'd1,
        ST_EMPTY   = 2'd2
    } estado_t;

    localparam logic [1:0] NIVEL_MAX = 2'd3;
    localparam logic [1:0] NIVEL_MIN = 2'd0;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle Tick every TICK_DIV clk cycles.
// The Tick is registered, so it appears in the cycle after the count reaches TICK_DIV-1.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic Tick
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (cnt_reg == CNT_LAST);
            cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign Tick = tick_reg;

endmodule

// File: rtl/nivel_comida_ctrl.sv
// Food-level controller: decays the 2-bit level on the time base, refills it while eating.
// Optional macro SLEEP_DECAY_EN adds input Dormido, which halves the decay rate while asleep.
module nivel_comida_ctrl
    import comida_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DECAY_TICKS = 30,
    parameter int FEED_TICKS  = 2,
    parameter int INIT_LEVEL  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Comiendo,
`ifdef SLEEP_DECAY_EN
    input  logic       Dormido,
`endif
    output logic [1:0] Nivel_Comida,
    output logic       Cambio_Nivel,
    output logic       Tick,
    output logic [1:0] Estado
);

    localparam int DW = $clog2(DECAY_TICKS + 1);
    localparam int FW = $clog2(FEED_TICKS + 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);
    localparam logic [FW-1:0] FEED_LAST  = FW'(FEED_TICKS - 1);

    estado_t       state_reg, state_next;
    logic [1:0]    level_reg, level_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic          cambio_reg;
    logic          tick;
    logic          decay_step;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .Tick  (tick)
    );

`ifdef SLEEP_DECAY_EN
    // While asleep, only every second tick counts towards decay.
    logic half_reg, half_next;

    always_comb begin
        half_next = half_reg;
        if (!Dormido || state_reg != ST_NORMAL) begin
            half_next = 1'b0;
        end else if (tick && !Comiendo) begin
            half_next = ~half_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) half_reg <= 1'b0;
        else        half_reg <= half_next;
    end

    assign decay_step = tick && (!Dormido || half_reg);
`else
    assign decay_step = tick;
`endif

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        dcnt_next  = dcnt_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            ST_NORMAL: begin
                // Eating takes priority over a coincident decay step; a full pet freezes decay.
                if (Comiendo) begin
                    if (level_reg != NIVEL_MAX) begin
                        state_next = ST_FEEDING;
                        fcnt_next  = '0;
                    end
                end else if (level_reg == NIVEL_MIN) begin
                    state_next = ST_EMPTY;
                end else if (decay_step) begin
                    if (dcnt_reg == DECAY_LAST) begin
                        dcnt_next  = '0;
                        level_next = level_reg - 2'd1;
                        if (level_next == NIVEL_MIN) state_next = ST_EMPTY;
                    end else begin
                        dcnt_next = dcnt_reg + DW'(1);
                    end
                end
            end
            ST_FEEDING: begin
                if (!Comiendo) begin
                    state_next = ST_NORMAL;
                    dcnt_next  = '0;
                end else if (tick) begin
                    if (fcnt_reg == FEED_LAST) begin
                        fcnt_next = '0;
                        if (level_reg != NIVEL_MAX) level_next = level_reg + 2'd1;
                        if (level_next == NIVEL_MAX) begin
                            state_next = ST_NORMAL;
                            dcnt_next  = '0;
                        end
                    end else begin
                        fcnt_next = fcnt_reg + FW'(1);
                    end
                end
            end
            ST_EMPTY: begin
                level_next = NIVEL_MIN;
                if (Comiendo) begin
                    state_next = ST_FEEDING;
                    fcnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_NORMAL;
                dcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_NORMAL;
            level_reg  <= 2'(INIT_LEVEL);
            dcnt_reg   <= '0;
            fcnt_reg   <= '0;
            cambio_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            level_reg  <= level_next;
            dcnt_reg   <= dcnt_next;
            fcnt_reg   <= fcnt_next;
            cambio_reg <= (level_next != level_reg);
        end
    end

    assign Nivel_Comida = level_reg;
    assign Cambio_Nivel = cambio_reg;
    assign Tick         = tick;
    assign Estado       = state_reg;

endmodule
